// File: rtl/sram_1rw_wmask_clr.sv
`default_nettype none
// ============================================================================
//  Module   : sram_1rw_wmask_clr
//  Purpose  : Single-port 1RW SRAM with per-lane write mask, registered read
//             data with a one-cycle rvalid pulse, and a clear FSM that sweeps
//             zeros through the whole array after reset or on clr_req.
//  Options  : SRAM_PARITY_EN - store one even-parity bit per lane, allow
//             parity-error injection on writes and flag mismatches on reads.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_1rw_wmask_clr #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 6,
    parameter int WSIZE      = 8
) (
    input  logic                        clk0,
    input  logic                        rst,
    input  logic                        csb0,
    input  logic                        web0,
    input  logic [ADDR_WIDTH-1:0]       addr0,
    input  logic [DATA_WIDTH/WSIZE-1:0] wmask0,
    input  logic [DATA_WIDTH-1:0]       din0,
    input  logic                        clr_req,
    input  logic                        perr_inj,
    output logic [DATA_WIDTH-1:0]       dout0,
    output logic                        rvalid,
    output logic                        busy,
    output logic                        perr
);

    localparam int NUM_WMASKS = DATA_WIDTH / WSIZE;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic [ADDR_WIDTH-1:0]   cnt_d;
    logic                    busy_q;
    logic                    rvalid_q;
    logic                    perr_q;
    logic                    perr_d;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic [DATA_WIDTH-1:0]   dout_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    w_access;
    logic                    w_write;
    logic                    w_read;

    // Accesses are only taken in IDLE; a clr_req in the same cycle wins and
    // the access is dropped.
    assign w_access = !csb0 && (state_q == ST_IDLE) && !clr_req;
    assign w_write  = w_access && !web0;
    assign w_read   = w_access && web0;

    assign cnt_d    = cnt_q + ADDR_WIDTH'(1);
    assign dout_d   = mem_q[addr0];

`ifdef SRAM_PARITY_EN
    logic [NUM_WMASKS-1:0]   par_q [DEPTH];

    // Any lane whose recomputed parity disagrees with the stored bit is an error.
    always_comb begin
        perr_d = 1'b0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            perr_d = perr_d | ((^dout_d[i*WSIZE +: WSIZE]) ^ par_q[addr0][i]);
        end
    end

    // Parity array follows the data array: zeroed by the sweep, per-lane on writes.
    always_ff @(posedge clk0) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                par_q[cnt_q] <= '0;
            end else if (w_write) begin
                for (int i = 0; i < NUM_WMASKS; i++) begin
                    if (wmask0[i]) begin
                        par_q[addr0][i] <= (^din0[i*WSIZE +: WSIZE]) ^ perr_inj;
                    end
                end
            end
        end
    end
`else
    logic unused_perr_inj;

    assign perr_d          = 1'b0;
    assign unused_perr_inj = perr_inj;
`endif

    // Storage array: the clear sweep has priority, otherwise masked lane writes.
    always_ff @(posedge clk0) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else if (w_write) begin
                for (int i = 0; i < NUM_WMASKS; i++) begin
                    if (wmask0[i]) begin
                        mem_q[addr0][i*WSIZE +: WSIZE] <= din0[i*WSIZE +: WSIZE];
                    end
                end
            end
        end
    end

    // Clear FSM plus registered read outputs; reset lands in CLEAR so a full
    // sweep always follows reset release.
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            dout_q   <= '0;
            rvalid_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            rvalid_q <= w_read;
            perr_q   <= w_read && perr_d;
            if (w_read) begin
                dout_q <= dout_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // clr_req is ignored here; the sweep ends when cnt wraps.
                    cnt_q <= cnt_d;
                    if (cnt_q == '1) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign dout0  = dout_q;
    assign rvalid = rvalid_q;
    assign busy   = busy_q;
    assign perr   = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw_wmask_clr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_1rw_wmask_clr
//  Purpose  : Directed scoreboard bench for sram_1rw_wmask_clr. Reads push
//             their hand-computed expected data into a queue; a monitor pops
//             and compares whenever rvalid is seen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sram_1rw_wmask_clr;

    localparam int DW = 128;
    localparam int AW = 6;
    localparam int NM = 16;
`ifdef SRAM_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    logic          clk0 = 1'b0;
    logic          rst;
    logic          csb0;
    logic          web0;
    logic [AW-1:0] addr0;
    logic [NM-1:0] wmask0;
    logic [DW-1:0] din0;
    logic          clr_req;
    logic          perr_inj;
    logic [DW-1:0] dout0;
    logic          rvalid;
    logic          busy;
    logic          perr;

    typedef struct {
        logic [DW-1:0] d;
        logic          p;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc;

    sram_1rw_wmask_clr #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .WSIZE     (8)
    ) dut (
        .clk0    (clk0),
        .rst     (rst),
        .csb0    (csb0),
        .web0    (web0),
        .addr0   (addr0),
        .wmask0  (wmask0),
        .din0    (din0),
        .clr_req (clr_req),
        .perr_inj(perr_inj),
        .dout0   (dout0),
        .rvalid  (rvalid),
        .busy    (busy),
        .perr    (perr)
    );

    always #5 clk0 = ~clk0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Monitor: every rvalid must match the oldest outstanding read.
    always @(negedge clk0) begin
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rvalid: got rvalid=1 dout0=%h required no read pending", dout0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rd_data", dout0, mon_e.d);
                check("rd_perr", {127'd0, perr}, {127'd0, mon_e.p});
            end
        end
    end

    task automatic idle_cyc(input int n);
        csb0 = 1'b1; web0 = 1'b1; clr_req = 1'b0; perr_inj = 1'b0;
        repeat (n) @(negedge clk0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NM-1:0] m, input logic inj);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m; perr_inj = inj;
        @(negedge clk0);
        csb0 = 1'b1; web0 = 1'b1; perr_inj = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic p);
        exp_t e;
        e.d = d; e.p = p;
        csb0 = 1'b0; web0 = 1'b1; addr0 = a;
        exp_q.push_back(e);
        @(negedge clk0);
        csb0 = 1'b1;
    endtask

    // Counts rising edges until busy falls; optionally pulses clr_req mid-sweep.
    task automatic count_busy(input int clr_at, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            @(posedge clk0);
            #1;
            cycles++;
            clr_req = (cycles == clr_at);
        end
        clr_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; csb0 = 1'b1; web0 = 1'b1; addr0 = '0; wmask0 = '0;
        din0 = '0; clr_req = 1'b0; perr_inj = 1'b0;
        repeat (3) @(negedge clk0);
        check("rst_dout0",  dout0, '0);
        check("rst_rvalid", {127'd0, rvalid}, 128'd0);
        check("rst_perr",   {127'd0, perr},   128'd0);
        check("rst_busy",   {127'd0, busy},   128'd1);

        // Reset release: sweep must take exactly 64 cycles.
        rst = 1'b0;
        count_busy(0, cyc);
        check("busy_after_rst", DW'(cyc), DW'(64));
        @(negedge clk0);
        rd(5, '0, 1'b0);
        idle_cyc(2);

        // Masked write over prior data, read straight after the write.
        wr(3, {16{8'h55}}, 16'hFFFF, 1'b0);
        wr(3, {16{8'hAA}}, 16'h00FF, 1'b0);
        rd(3, {{8{8'h55}}, {8{8'hAA}}}, 1'b0);
        idle_cyc(1);

        // Back-to-back reads.
        wr(1, DW'(8'h11), 16'hFFFF, 1'b0);
        wr(2, DW'(8'h22), 16'hFFFF, 1'b0);
        wr(3, DW'(8'h33), 16'hFFFF, 1'b0);
        rd(1, DW'(8'h11), 1'b0);
        rd(2, DW'(8'h22), 1'b0);
        rd(3, DW'(8'h33), 1'b0);
        idle_cyc(2);

        // Edge lanes only, then a deselected write and read are dropped.
        wr(20, '1, 16'hFFFF, 1'b0);
        wr(20, '0, 16'h8001, 1'b0);
        csb0 = 1'b1; web0 = 1'b0; addr0 = 20; din0 = '0; wmask0 = 16'hFFFF;
        @(negedge clk0);
        web0 = 1'b1;
        @(negedge clk0);
        rd(20, {8'h00, {14{8'hFF}}, 8'h00}, 1'b0);
        idle_cyc(2);

        // clr_req with a concurrent read, reads held during the sweep,
        // and a second clr_req mid-sweep that must not extend it.
        wr(10, DW'(16'h1234), 16'hFFFF, 1'b0);
        clr_req = 1'b1; csb0 = 1'b0; web0 = 1'b1; addr0 = 10;
        @(posedge clk0);
        #1;
        clr_req = 1'b0;
        check("clr_busy", {127'd0, busy}, 128'd1);
        count_busy(10, cyc);
        csb0 = 1'b1;
        check("busy_after_clr", DW'(cyc), DW'(64));
        @(negedge clk0);
        rd(10, '0, 1'b0);
        idle_cyc(2);

        // Reset 20 cycles into a sweep restarts it from zero.
        wr(4, DW'(16'hBEEF), 16'hFFFF, 1'b0);
        rd(4, DW'(16'hBEEF), 1'b0);
        idle_cyc(1);
        clr_req = 1'b1;
        @(posedge clk0);
        #1;
        clr_req = 1'b0;
        repeat (20) @(posedge clk0);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_dout0", dout0, '0);
        check("midrst_busy", {127'd0, busy}, 128'd1);
        @(posedge clk0);
        #1;
        rst = 1'b0;
        count_busy(0, cyc);
        check("busy_after_midrst", DW'(cyc), DW'(64));
        @(negedge clk0);

        // Parity injection on lane 0, then a clean rewrite.
        wr(7, DW'(8'hA5), 16'h0001, 1'b1);
        rd(7, DW'(8'hA5), PAR);
        wr(7, DW'(8'hA5), 16'h0001, 1'b0);
        rd(7, DW'(8'hA5), 1'b0);
        idle_cyc(3);

        check("sb_drained", DW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_1rw_wmask_clr.md
SRAM_1RW_WMASK_CLR -- requirements
Module: sram_1rw_wmask_clr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: word width in bits; SHALL be a multiple of WSIZE.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6: address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter WSIZE, default 8: bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WSIZE.
REQ-004 SHALL have port clk0, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port csb0, input, 1 bit: chip select, active low.
REQ-007 SHALL have port web0, input, 1 bit: write enable, active low; 1 = read.
REQ-008 SHALL have port addr0, input, ADDR_WIDTH bits: word address.
REQ-009 SHALL have port wmask0, input, NUM_WMASKS bits: per-lane write enable; bit i covers din0[i*WSIZE +: WSIZE].
REQ-010 SHALL have port din0, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port clr_req, input, 1 bit: one-cycle request to zero the whole array.
REQ-012 SHALL have port perr_inj, input, 1 bit: parity-error injection on the current write (parity build only).
REQ-013 SHALL have port dout0, output, DATA_WIDTH bits: registered read data.
REQ-014 SHALL have port rvalid, output, 1 bit: one-cycle pulse, dout0 valid.
REQ-015 SHALL have port busy, output, 1 bit: clear sweep in progress; accesses are dropped.
REQ-016 SHALL have port perr, output, 1 bit: parity error on the current read, qualified by rvalid.

Function
REQ-017 SHALL accept an access at a rising edge only when csb0=0 and busy=0; otherwise the access is dropped with no state change.
REQ-018 Write (web0=0): SHALL update only lanes with wmask0[i]=1 at the accepting edge; dout0 SHALL hold; rvalid SHALL stay 0.
REQ-019 Read (web0=1): dout0 SHALL load mem[addr0] at the accepting edge (latency 1); rvalid=1 for exactly that following cycle; dout0 SHALL hold its value until the next accepted read.
REQ-020 Back-to-back reads SHALL each produce one rvalid pulse, one cycle after the read, at full throughput.
REQ-021 A read that directly follows a write to the same address SHALL return the newly written data.
REQ-022 The clear FSM SHALL have two states: IDLE (busy=0) and CLEAR (busy=1).
REQ-023 In CLEAR, SHALL write all-zero data to address cnt each cycle, cnt counting 0 to 2**ADDR_WIDTH-1, then go to IDLE; the sweep lasts exactly 2**ADDR_WIDTH cycles.
REQ-024 clr_req=1 in IDLE: SHALL go to CLEAR with cnt=0 at the next edge; any access presented in the same cycle is dropped.
REQ-025 clr_req while already in CLEAR SHALL be ignored; the sweep SHALL neither restart nor extend.
REQ-026 cnt SHALL be ADDR_WIDTH bits wide; its wrap from all-ones to 0 SHALL coincide with the CLEAR-to-IDLE transition.
REQ-027 Cleared words SHALL carry correct (zero) parity in the parity build.

Reset
REQ-028 While rst=1: dout0=0, rvalid=0, perr=0, state=CLEAR, cnt=0, busy=1.
REQ-029 After rst deasserts, SHALL run a full clear sweep automatically; first access accepted on cycle 2**ADDR_WIDTH after release.
REQ-030 rst asserted mid-sweep or mid-access SHALL abort it immediately; the sweep restarts from cnt=0.

Configuration
REQ-031 With SRAM_PARITY_EN defined: one even-parity bit SHALL be stored per lane and written with its lane data; perr_inj=1 on a write SHALL invert the stored parity of the enabled lanes; a read SHALL assert perr together with rvalid if any lane mismatches.
REQ-032 Without SRAM_PARITY_EN: no parity storage; perr SHALL be constant 0; perr_inj SHALL be ignored.

Verification
REQ-033 Release rst -> busy=1 for exactly 64 cycles (defaults); then read addr 5 -> dout0=0, rvalid one pulse.
REQ-034 Write addr 3, din0=all 0xAA lanes, wmask0=16'h00FF, over prior all-0x55 data -> read addr 3 = 0x5555_5555_5555_5555_AAAA_AAAA_AAAA_AAAA.
REQ-035 Write addr 10 = 0x1234; pulse clr_req; hold csb0=0 during busy -> no rvalid for 64 cycles; then read addr 10 returns 0.
REQ-036 Assert rst at sweep cycle 20 for 1 cycle -> busy stays high for 64 cycles after release.
REQ-037 Reads to addrs 1, 2, 3 on consecutive cycles (data 0x11, 0x22, 0x33) -> three consecutive rvalid pulses with data in order.
REQ-038 SRAM_PARITY_EN: write addr 7 with perr_inj=1 and wmask0=16'h0001 -> read addr 7 gives perr=1 with rvalid; rewrite without perr_inj -> perr=0.
